// File: rtl/piece_queue_if.sv
// Handshake bundle between the piece generator, the piece queue and the game controller.
// The queue uses the slave modport; the controller/generator side uses master.
interface piece_queue_if;
  logic       gen_ready;
  logic [2:0] gen_piece;
  logic       gen_enable;
  logic       take;
  logic [2:0] head;
  logic       head_valid;
  logic [2:0] preview;
  logic       preview_valid;
  logic [2:0] count;

  modport master (
    output gen_ready, gen_piece, take,
    input  gen_enable, head, head_valid, preview, preview_valid, count
  );

  modport slave (
    input  gen_ready, gen_piece, take,
    output gen_enable, head, head_valid, preview, preview_valid, count
  );
endinterface

// File: rtl/piece_queue.sv
// Circular queue of upcoming game pieces with a FILL/SERVE gate on the head.
// Optional feature macro PIECE_QUEUE_NOREPEAT_EN rejects a candidate equal to the last accepted piece.
module piece_queue #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          nreset,
  piece_queue_if.slave  q
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] INVALID = 3'b111;

  typedef enum logic {FILL, SERVE} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]        count_q, count_d;
  logic [2:0]        mem_q [DEPTH];
  logic [2:0]        mem_d [DEPTH];
  logic              push, pop, head_valid, preview_valid, repeat_ok;

`ifdef PIECE_QUEUE_NOREPEAT_EN
  logic [2:0]        last_q, last_d;
`endif

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    mem_d         = mem_q;
    head_valid    = (state_q == SERVE) && (count_q != 3'd0);
    preview_valid = (state_q == SERVE) && (count_q >= 3'd2);
`ifdef PIECE_QUEUE_NOREPEAT_EN
    last_d        = last_q;
    repeat_ok     = (q.gen_piece != last_q);
`else
    repeat_ok     = 1'b1;
`endif

    pop  = q.take && head_valid;
    push = q.gen_ready && (q.gen_piece != INVALID) && repeat_ok &&
           ((count_q < 3'(DEPTH)) || pop);

    if (push) begin
      mem_d[wr_ptr_q] = q.gen_piece;
      wr_ptr_d        = ptr_next(wr_ptr_q);
`ifdef PIECE_QUEUE_NOREPEAT_EN
      last_d          = q.gen_piece;
`endif
    end
    if (pop) rd_ptr_d = ptr_next(rd_ptr_q);

    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    // The state follows the count it is about to hold, so the head opens on the filling edge.
    case (state_q)
      FILL:    if (count_d == 3'(DEPTH)) state_d = SERVE;
      SERVE:   if (count_d == 3'd0)      state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= FILL;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 3'b000;
`ifdef PIECE_QUEUE_NOREPEAT_EN
      last_q   <= INVALID;
`endif
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
`ifdef PIECE_QUEUE_NOREPEAT_EN
      last_q   <= last_d;
`endif
    end
  end

  assign q.head          = mem_q[rd_ptr_q];
  assign q.preview       = mem_q[ptr_next(rd_ptr_q)];
  assign q.head_valid    = head_valid;
  assign q.preview_valid = preview_valid;
  assign q.count         = count_q;
  assign q.gen_enable    = (count_q < 3'(DEPTH)) || q.take;

endmodule

// File: tb/tb_piece_queue.sv
// Directed bench for piece_queue (DEPTH 4): fill, overflow, push-with-pop, drain, invalid codes,
// repeat filter (either build of PIECE_QUEUE_NOREPEAT_EN) and asynchronous reset.
module tb_piece_queue;

  logic clk;
  logic nreset;
  int   vectors;
  int   miscompares;

  piece_queue_if pq_if ();

  piece_queue #(.DEPTH(4)) dut (
    .clk    (clk),
    .nreset (nreset),
    .q      (pq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs on the falling edge, then let the rising edge act on them.
  task automatic applyStimulus(input logic ready, input logic [2:0] piece, input logic take);
    @(negedge clk);
    pq_if.gen_ready = ready;
    pq_if.gen_piece = piece;
    pq_if.take      = take;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] cnt, input logic hv,
                          input logic [2:0] hd, input logic pv, input logic [2:0] pr);
    checkOutput({tag, " count"}, 8'(pq_if.count), 8'(cnt));
    checkOutput({tag, " head_valid"}, 8'(pq_if.head_valid), 8'(hv));
    if (hv) checkOutput({tag, " head"}, 8'(pq_if.head), 8'(hd));
    checkOutput({tag, " preview_valid"}, 8'(pq_if.preview_valid), 8'(pv));
    if (pv) checkOutput({tag, " preview"}, 8'(pq_if.preview), 8'(pr));
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    nreset          = 1'b0;
    pq_if.gen_ready = 1'b0;
    pq_if.gen_piece = 3'b000;
    pq_if.take      = 1'b0;

    #12;
    checkAll("reset", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    checkOutput("reset head", 8'(pq_if.head), 8'd0);
    checkOutput("reset preview", 8'(pq_if.preview), 8'd0);
    checkOutput("reset gen_enable", 8'(pq_if.gen_enable), 8'd1);
    @(negedge clk);
    nreset = 1'b1;

    // Fill 2,5,1,3: head stays hidden until the queue is full.
    applyStimulus(1'b1, 3'd2, 1'b0);
    checkAll("fill1", 3'd1, 1'b0, 3'd0, 1'b0, 3'd0);
    applyStimulus(1'b1, 3'd5, 1'b0);
    checkAll("fill2", 3'd2, 1'b0, 3'd0, 1'b0, 3'd0);
    applyStimulus(1'b1, 3'd1, 1'b0);
    checkAll("fill3", 3'd3, 1'b0, 3'd0, 1'b0, 3'd0);
    applyStimulus(1'b1, 3'd3, 1'b0);
    checkAll("fill4", 3'd4, 1'b1, 3'd2, 1'b1, 3'd5);
    checkOutput("full gen_enable", 8'(pq_if.gen_enable), 8'd0);

    // Full without pop drops the candidate.
    applyStimulus(1'b1, 3'd6, 1'b0);
    checkAll("full_drop", 3'd4, 1'b1, 3'd2, 1'b1, 3'd5);
    checkOutput("take gen_enable", 8'(pq_if.gen_enable), 8'd0);

    // Push 6 together with popping 2.
    applyStimulus(1'b1, 3'd6, 1'b1);
    checkAll("pushpop", 3'd4, 1'b1, 3'd5, 1'b1, 3'd1);
    checkOutput("take gen_enable comb", 8'(pq_if.gen_enable), 8'd1);

    applyStimulus(1'b0, 3'd0, 1'b1);
    checkAll("pop1", 3'd3, 1'b1, 3'd1, 1'b1, 3'd3);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkAll("pop2", 3'd2, 1'b1, 3'd3, 1'b1, 3'd6);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkAll("pop3", 3'd1, 1'b1, 3'd6, 1'b0, 3'd0);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkAll("pop_last", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkAll("take_empty", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);

    // Invalid code on an empty queue.
    applyStimulus(1'b1, 3'b111, 1'b0);
    checkAll("invalid", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);

    // Repeat filter: 4,4,4,0.
    applyStimulus(1'b1, 3'd4, 1'b0);
    applyStimulus(1'b1, 3'd4, 1'b0);
    applyStimulus(1'b1, 3'd4, 1'b0);
    applyStimulus(1'b1, 3'd0, 1'b0);
`ifdef PIECE_QUEUE_NOREPEAT_EN
    checkAll("norepeat", 3'd2, 1'b0, 3'd0, 1'b0, 3'd0);
`else
    checkAll("repeat", 3'd4, 1'b1, 3'd4, 1'b1, 3'd4);
`endif

    // Reset mid-operation, then refill and pop once to reach SERVE with count 3.
    @(negedge clk);
    pq_if.gen_ready = 1'b0;
    nreset = 1'b0;
    #1;
    checkOutput("midreset count", 8'(pq_if.count), 8'd0);
    @(negedge clk);
    nreset = 1'b1;
    applyStimulus(1'b1, 3'd2, 1'b0);
    applyStimulus(1'b1, 3'd5, 1'b0);
    applyStimulus(1'b1, 3'd1, 1'b0);
    applyStimulus(1'b1, 3'd3, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkAll("serve3", 3'd3, 1'b1, 3'd5, 1'b1, 3'd1);

    // Asynchronous reset between clock edges.
    #2;
    pq_if.take = 1'b0;
    nreset     = 1'b0;
    #1;
    checkAll("async", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    checkOutput("async head", 8'(pq_if.head), 8'd0);
    checkOutput("async preview", 8'(pq_if.preview), 8'd0);
    checkOutput("async gen_enable", 8'(pq_if.gen_enable), 8'd1);
    @(negedge clk);
    nreset = 1'b1;
    applyStimulus(1'b1, 3'd4, 1'b0);
    checkAll("refill", 3'd1, 1'b0, 3'd0, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
